// File: rtl/frame_cfg_pkg.sv
// Purpose: shared types and constants for the frame configuration loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package frame_cfg_pkg;

    // Loader FSM states; CHECK is reachable only when FRAME_CONFIG_CHECKSUM_EN is defined
    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        HEADER = 3'd1,
        DATA   = 3'd2,
        STROBE = 3'd3,
        DONE   = 3'd4,
        CHECK  = 3'd5
    } state_t;

    // Header word field positions
    localparam int HDR_END    = 31;
    localparam int HDR_COL_HI = 23;
    localparam int HDR_COL_LO = 16;
    localparam int HDR_FRM_HI = 7;
    localparam int HDR_FRM_LO = 0;

    // Stream synchronisation word used unless the instance overrides it
    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Purpose: registered one-hot decode of column/frame into FrameStrobe, held for StrobeCycles.
// Latency: strobe rises the cycle after load, stays high StrobeCycles cycles.
// Backpressure: none; last flags the final high cycle so the FSM can leave STROBE in step.
module frame_strobe_decoder
    import frame_cfg_pkg::*;
#(
    parameter int NumColumns      = 4,
    parameter int MaxFramesPerCol = 20,
    parameter int StrobeCycles    = 2,
    parameter int ColW            = 2,
    parameter int FrmW            = 5
)(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  load,
    input  logic [ColW-1:0]                       col,
    input  logic [FrmW-1:0]                       frm,
    output logic [NumColumns*MaxFramesPerCol-1:0] strobe,
    output logic                                  last
);

    localparam int NumBits = NumColumns * MaxFramesPerCol;
    localparam int CntW    = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

    logic [NumBits-1:0] onehot;
    logic [CntW-1:0]    hold_cnt;
    int                 idx;

    // Flatten column/frame into a single strobe bit position
    always_comb begin
        idx = int'(col) * MaxFramesPerCol + int'(frm);
        for (int i = 0; i < NumBits; i++) begin
            onehot[i] = (i == idx);
        end
    end

    // Load the one-hot pattern, count down the hold, then clear
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe   <= '0;
            hold_cnt <= '0;
        end else if (load) begin
            strobe   <= onehot;
            hold_cnt <= CntW'(StrobeCycles - 1);
        end else if (|strobe) begin
            if (hold_cnt == '0) begin
                strobe <= '0;
            end else begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    assign last = (|strobe) && (hold_cnt == '0);

endmodule

// File: rtl/frame_config_loader.sv
// Purpose: turns a 32-bit config stream into FrameData rows and one FrameStrobe pulse per frame.
// Latency: row visible 1 cycle after acceptance; strobe t+1..t+StrobeCycles after last row at t.
// Backpressure: s_ready low only while a strobe is held (and for the reset cycle).
// Optional checksum trailer and err_crc port enabled by FRAME_CONFIG_CHECKSUM_EN.
module frame_config_loader
    import frame_cfg_pkg::*;
#(
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter int          NumRows         = 4,
    parameter int          NumColumns      = 4,
    parameter int          StrobeCycles    = 2,
    parameter logic [31:0] SyncWord        = DEFAULT_SYNC_WORD
)(
    input  logic                                  UserCLK,
    input  logic                                  Reset,
    input  logic [FrameBitsPerRow-1:0]            s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  cfg_done,
    output logic                                  err_addr
`ifdef FRAME_CONFIG_CHECKSUM_EN
    ,
    output logic                                  err_crc
`endif
);

    localparam int ColW = (NumColumns > 1)      ? $clog2(NumColumns)      : 1;
    localparam int FrmW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam int RowW = (NumRows > 1)         ? $clog2(NumRows)         : 1;

    state_t                     state;
    logic [RowW-1:0]            row_q;
    logic                       drop_q;
    logic [ColW-1:0]            col_q;
    logic [FrmW-1:0]            frm_q;
    logic [FrameBitsPerRow-1:0] rows_q [NumRows];
`ifdef FRAME_CONFIG_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0] csum_q;
`endif

    logic       xfer;
    logic       is_sync;
    logic       hdr_end;
    logic [7:0] hdr_col;
    logic [7:0] hdr_frm;
    logic       addr_bad;
    logic       row_last;
    logic       strobe_load;
    logic       strobe_last;

    assign xfer     = s_valid && s_ready;
    assign is_sync  = (s_data == SyncWord);
    assign hdr_end  = s_data[HDR_END];
    assign hdr_col  = s_data[HDR_COL_HI:HDR_COL_LO];
    assign hdr_frm  = s_data[HDR_FRM_HI:HDR_FRM_LO];
    assign addr_bad = ({24'd0, hdr_col} >= 32'(NumColumns)) ||
                      ({24'd0, hdr_frm} >= 32'(MaxFramesPerCol));
    assign row_last = (row_q == RowW'(NumRows - 1));

    // Strobe is loaded on the same edge that accepts the last row of a valid frame
    assign strobe_load = (state == DATA) && xfer && row_last && !drop_q;

    // Busy whenever a configuration is in progress
    assign busy = (state != SYNC) && (state != DONE);

    // Row registers drive the fabric-wide FrameData bus
    always_comb begin
        FrameData = '0;
        for (int r = 0; r < NumRows; r++) begin
            FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] = rows_q[r];
        end
    end

    // Stream-parsing FSM with registered handshake and status flags
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state    <= SYNC;
            s_ready  <= 1'b0;
            row_q    <= '0;
            drop_q   <= 1'b0;
            col_q    <= '0;
            frm_q    <= '0;
            cfg_done <= 1'b0;
            err_addr <= 1'b0;
            for (int r = 0; r < NumRows; r++) begin
                rows_q[r] <= '0;
            end
`ifdef FRAME_CONFIG_CHECKSUM_EN
            csum_q   <= '0;
            err_crc  <= 1'b0;
`endif
        end else begin
            s_ready <= 1'b1;
            case (state)
                SYNC, DONE: begin
                    if (xfer && is_sync) begin
                        state    <= HEADER;
                        cfg_done <= 1'b0;
`ifdef FRAME_CONFIG_CHECKSUM_EN
                        csum_q   <= '0;
`endif
                    end
                end
                HEADER: begin
                    if (xfer) begin
`ifdef FRAME_CONFIG_CHECKSUM_EN
                        csum_q <= csum_q ^ s_data;
`endif
                        row_q <= '0;
                        if (hdr_end) begin
`ifdef FRAME_CONFIG_CHECKSUM_EN
                            state    <= CHECK;
`else
                            state    <= DONE;
                            cfg_done <= 1'b1;
`endif
                        end else if (addr_bad) begin
                            err_addr <= 1'b1;
                            drop_q   <= 1'b1;
                            state    <= DATA;
                        end else begin
                            col_q  <= hdr_col[ColW-1:0];
                            frm_q  <= hdr_frm[FrmW-1:0];
                            drop_q <= 1'b0;
                            state  <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
`ifdef FRAME_CONFIG_CHECKSUM_EN
                        csum_q <= csum_q ^ s_data;
`endif
                        if (!drop_q) begin
                            rows_q[row_q] <= s_data;
                        end
                        if (row_last) begin
                            row_q <= '0;
                            if (drop_q) begin
                                state <= HEADER;
                            end else begin
                                state   <= STROBE;
                                s_ready <= 1'b0;
                            end
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                STROBE: begin
                    if (strobe_last) begin
                        state <= HEADER;
                    end else begin
                        s_ready <= 1'b0;
                    end
                end
`ifdef FRAME_CONFIG_CHECKSUM_EN
                CHECK: begin
                    if (xfer) begin
                        state <= DONE;
                        if (s_data == csum_q) begin
                            cfg_done <= 1'b1;
                        end else begin
                            err_crc <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

    frame_strobe_decoder #(
        .NumColumns      (NumColumns),
        .MaxFramesPerCol (MaxFramesPerCol),
        .StrobeCycles    (StrobeCycles),
        .ColW            (ColW),
        .FrmW            (FrmW)
    ) u_strobe (
        .clk    (UserCLK),
        .rst    (Reset),
        .load   (strobe_load),
        .col    (col_q),
        .frm    (frm_q),
        .strobe (FrameStrobe),
        .last   (strobe_last)
    );

endmodule

// File: tb/tb_frame_config_loader.sv
// Purpose: randomized scoreboard bench for frame_config_loader.
// Latency: expects strobes 1 cycle after the last row, held 2 cycles.
// Backpressure: driver waits on s_ready before every word.
module tb_frame_config_loader;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int FRMS = 20;
    localparam int STROBE_LEN = 2;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    typedef struct {
        int           idx;
        logic [127:0] data;
        int           dur;
    } exp_t;

    logic         clk = 1'b0;
    logic         Reset = 1'b1;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] FrameData;
    logic [79:0]  FrameStrobe;
    logic         busy;
    logic         cfg_done;
    logic         err_addr;
`ifdef FRAME_CONFIG_CHECKSUM_EN
    logic         err_crc;
`endif

    int checks = 0;
    int errors = 0;

    exp_t         exp_q[$];
    logic [127:0] model_data = '0;
    logic         model_err  = 1'b0;
    logic [31:0]  run_xor    = '0;

    always #5 clk = ~clk;

    frame_config_loader dut (
        .UserCLK     (clk),
        .Reset       (Reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .cfg_done    (cfg_done),
        .err_addr    (err_addr)
`ifdef FRAME_CONFIG_CHECKSUM_EN
        ,
        .err_crc     (err_crc)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one word, wait for s_ready (bounded), let it transfer on the next edge
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            errors++;
            $display("FAIL send_timeout: s_ready stuck at 0 for word %0h", w);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_sync();
        send(SYNC);
        run_xor = '0;
    endtask

    // One frame: header plus ROWS data words; model decides strobe or drop
    task automatic send_frame(input int col, input int frm, input int dur);
        logic [31:0]  hdr;
        logic [31:0]  w;
        logic [127:0] nd;
        exp_t         e;
        hdr = {1'b0, 7'($urandom), 8'(col), 8'($urandom), 8'(frm)};
        send(hdr);
        run_xor ^= hdr;
        nd = model_data;
        for (int r = 0; r < ROWS; r++) begin
            w = $urandom;
            nd[r*32 +: 32] = w;
            if (r == ROWS - 1 && col < COLS && frm < FRMS) begin
                model_data = nd;
                e.idx  = col * FRMS + frm;
                e.data = nd;
                e.dur  = dur;
                exp_q.push_back(e);
            end
            send(w);
            run_xor ^= w;
        end
        if (!(col < COLS && frm < FRMS)) model_err = 1'b1;
        check("err_addr_after_frame", 128'(err_addr), 128'(model_err));
        check("framedata_after_frame", FrameData, model_data);
    endtask

    // END header, followed by the checksum word when that feature is built in
    task automatic send_end(input logic corrupt);
        logic [31:0] endw;
        endw = 32'h8000_0000;
        send(endw);
        run_xor ^= endw;
`ifdef FRAME_CONFIG_CHECKSUM_EN
        check("busy_in_check", 128'(busy), 128'(1));
        send(corrupt ? (run_xor ^ 32'h1) : run_xor);
        check("err_crc_after_end", 128'(err_crc), 128'(corrupt));
        check("cfg_done_after_end", 128'(cfg_done), 128'(!corrupt));
`else
        check("cfg_done_after_end", 128'(cfg_done), 128'(1));
        if (corrupt) check("no_crc_build", 128'(cfg_done), 128'(1));
`endif
        check("busy_after_end", 128'(busy), 128'(0));
    endtask

    // Monitor: measure each strobe pulse and score it against the expected queue
    bit           in_strobe = 1'b0;
    int           obs_dur;
    int           obs_idx;
    logic [127:0] obs_data;
    always @(negedge clk) begin
        exp_t e;
        if (FrameStrobe != '0) begin
            if (!in_strobe) begin
                in_strobe = 1'b1;
                obs_dur   = 0;
                obs_data  = FrameData;
                for (int i = 0; i < 80; i++) if (FrameStrobe[i]) obs_idx = i;
                check("strobe_onehot", 128'($countones(FrameStrobe)), 128'(1));
            end
            obs_dur++;
            check("s_ready_low_in_strobe", 128'(s_ready), 128'(0));
            check("framedata_stable", FrameData, obs_data);
        end else if (in_strobe) begin
            in_strobe = 1'b0;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got bit %0d expected none", obs_idx);
            end else begin
                e = exp_q.pop_front();
                check("strobe_bit", 128'(obs_idx), 128'(e.idx));
                check("strobe_data", obs_data, e.data);
                check("strobe_len", 128'(obs_dur), 128'(e.dur));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_s_ready", 128'(s_ready), 128'(0));
        check("reset_strobe", 128'(FrameStrobe), 128'(0));
        check("reset_data", FrameData, 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(cfg_done), 128'(0));
        check("reset_err", 128'(err_addr), 128'(0));
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        check("s_ready_after_reset", 128'(s_ready), 128'(1));

        // Garbage before sync is discarded
        send(32'h1234_5678);
        check("busy_before_sync", 128'(busy), 128'(0));
        send_sync();
        check("busy_after_sync", 128'(busy), 128'(1));

        // Directed frames: good, bad column, bad frame, frame 0
        send_frame(1, 3, STROBE_LEN);
        send_frame(4, 0, STROBE_LEN);
        send_frame(0, 20, STROBE_LEN);
        send_frame(0, 0, STROBE_LEN);
        send_frame(3, 19, STROBE_LEN);

        // Randomized frames, some out of range
        for (int k = 0; k < 25; k++) begin
            send_frame($urandom_range(0, 5), $urandom_range(0, 22), STROBE_LEN);
        end

        send_end(1'b0);
        send(32'hDEAD_BEEF);
        check("done_ignores_garbage", 128'(busy), 128'(0));
        send_sync();
        check("cfg_done_cleared", 128'(cfg_done), 128'(0));
        check("err_addr_sticky", 128'(err_addr), 128'(model_err));

        // Reconfiguration with a corrupted trailer (checksum build flags it)
        send_frame(2, 7, STROBE_LEN);
        send_end(1'b1);
        send_sync();

        // Reset during the strobe: strobe lasts one cycle, everything clears
        send_frame(2, 11, 1);
        Reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midreset_strobe", 128'(FrameStrobe), 128'(0));
        check("midreset_data", FrameData, 128'(0));
        check("midreset_busy", 128'(busy), 128'(0));
        check("midreset_s_ready", 128'(s_ready), 128'(0));
        check("midreset_err", 128'(err_addr), 128'(0));
        model_data = '0;
        model_err  = 1'b0;
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        send(32'h0000_0001);
        check("sync_state_after_reset", 128'(busy), 128'(0));

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
